// File: rtl/ram_regfile.sv
// Parametrised register file: base-offset address decode, range flagging, and a
// self-clearing array after reset. Define RAM_REGFILE_INDIRECT_EN to decode INDF through fsr.
module ram_regfile #(
  parameter int DW    = 8,
  parameter int AW    = 5,
  parameter int BASE  = 8,
  parameter int DEPTH = 24
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] din,
  input  logic [AW-1:0] fsr,
  output logic [DW-1:0] dout,
  output logic          busy,
  output logic          err
);

  localparam int IW = $clog2(DEPTH);
  localparam logic [IW-1:0] PTR_LAST = IW'(DEPTH - 1);

  typedef enum logic {
    CLEAR = 1'b0,
    IDLE  = 1'b1
  } state_t;

  state_t        state, state_nxt;
  logic [IW-1:0] ptr;
  logic          clear_we;

  logic [AW-1:0] ea;
  logic [31:0]   ea_w;
  logic          valid;
  logic [IW-1:0] idx;

  logic [IW-1:0] idx_q;
  logic          valid_q;
  logic          busy_q;

  logic [DW-1:0] ram [DEPTH];

  // ---------------------------------------------------------------------------
  // Address decode
  // ---------------------------------------------------------------------------
`ifdef RAM_REGFILE_INDIRECT_EN
  logic indf_zero;

  always_comb begin
    ea        = (addr == '0) ? fsr : addr;
    // INDF pointing at INDF would recurse; treat it as out of range.
    indf_zero = (addr == '0) && (fsr == '0);
  end
`else
  logic indf_zero;
  logic unused_fsr;

  always_comb begin
    ea        = addr;
    indf_zero = 1'b0;
  end
  assign unused_fsr = ^fsr;
`endif

  always_comb begin
    ea_w  = 32'(ea);
    valid = (ea_w >= 32'(BASE)) && (ea_w < 32'(BASE + DEPTH)) && !indf_zero;
    idx   = IW'(ea - AW'(BASE));
  end

  // ---------------------------------------------------------------------------
  // Clear sequencer: state register / next state / outputs
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking (<=) so every flop samples the
  // pre-edge values; combinational blocks use blocking (=) with a default first.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= CLEAR;
      ptr   <= '0;
    end else begin
      state <= state_nxt;
      if (clear_we && (ptr != PTR_LAST)) ptr <= ptr + IW'(1);
    end
  end

  // NOTE: every variable assigned in always_comb gets a default up front, so no latch is inferred.
  always_comb begin
    state_nxt = state;
    if ((state == CLEAR) && (ptr == PTR_LAST)) state_nxt = IDLE;
  end

  always_comb begin
    busy     = (state == CLEAR);
    clear_we = (state == CLEAR);
  end

  // ---------------------------------------------------------------------------
  // Storage
  // ---------------------------------------------------------------------------
  // NOTE: the array has no reset branch; the clear sequencer zeroes it one word
  // per cycle instead, which keeps it mappable onto RAM/register-file macros.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (clear_we) begin
        ram[ptr] <= '0;
      end else if (we && valid) begin
        ram[idx] <= din;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Read pipeline and range error
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      idx_q   <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b1;
      err     <= 1'b0;
    end else begin
      idx_q   <= idx;
      valid_q <= valid;
      busy_q  <= busy;
      err     <= !valid && !busy;
    end
  end

  // The array read is after the edge, so a write at that edge is seen (write-first).
  always_comb begin
    dout = '0;
    if (!busy_q && valid_q) dout = ram[idx_q];
  end

endmodule

// File: tb/tb_ram_regfile.sv
// Randomised scoreboard bench for ram_regfile: a behavioural model predicts
// dout/err/busy after each edge; a monitor pops and compares on the falling edge.
module tb_ram_regfile;

  localparam int DW    = 8;
  localparam int AW    = 5;
  localparam int BASE  = 8;
  localparam int DEPTH = 24;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          we  = 1'b0;
  logic [AW-1:0] addr = '0;
  logic [DW-1:0] din  = '0;
  logic [AW-1:0] fsr  = '0;
  logic [DW-1:0] dout;
  logic          busy;
  logic          err;

  ram_regfile #(.DW(DW), .AW(AW), .BASE(BASE), .DEPTH(DEPTH)) dut (
    .clk  (clk),
    .rst  (rst),
    .we   (we),
    .addr (addr),
    .din  (din),
    .fsr  (fsr),
    .dout (dout),
    .busy (busy),
    .err  (err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [DW-1:0] dout;
    logic          err;
    logic          busy;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_errors = 0;

  // Reference model: word contents plus number of clear edges still to come.
  logic [DW-1:0] mem [DEPTH];
  int            clr_left = DEPTH;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_edge(input logic r, input logic w, input int a, input logic [DW-1:0] d,
                            input int f, output exp_t e);
    int   ea;
    bit   ok;
    bit   busy_now;
    e = '0;
    if (r) begin
      clr_left = DEPTH;
      e.busy   = 1'b1;
      return;
    end
    busy_now = (clr_left > 0);
    if (busy_now) begin
      mem[DEPTH - clr_left] = '0;
      clr_left--;
    end
    ea = a;
    ok = 1'b1;
`ifdef RAM_REGFILE_INDIRECT_EN
    if (a == 0) begin
      ea = f;
      if (f == 0) ok = 1'b0;
    end
`endif
    if (ea < BASE || ea >= BASE + DEPTH) ok = 1'b0;
    if (w && ok && !busy_now) mem[ea - BASE] = d;
    e.dout = (busy_now || !ok) ? '0 : mem[ea - BASE];
    e.err  = !ok && !busy_now;
    e.busy = (clr_left > 0);
  endtask

  // One clock of stimulus; the expectation for the outputs after this edge is queued.
  task automatic step(input logic r, input logic w, input int a, input logic [DW-1:0] d,
                      input int f = 0);
    exp_t e;
    rst  = r;
    we   = w;
    addr = AW'(a);
    din  = d;
    fsr  = AW'(f);
    model_edge(r, w, a, d, f, e);
    @(posedge clk);
    sb.push_back(e);
    #1;
  endtask

  task automatic nop(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, BASE, '0);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check("dout", 32'(dout), 32'(e.dout));
      check("err",  32'(err),  32'(e.err));
      check("busy", 32'(busy), 32'(e.busy));
    end
  end

  initial begin
    for (int i = 0; i < DEPTH; i++) mem[i] = '0;
    #1;

    // Reset, then a write to 9 during CLEAR and one on the finishing edge (both dropped).
    step(1'b1, 1'b0, 0, '0);
    step(1'b1, 1'b0, 0, '0);
    step(1'b0, 1'b0, 7, '0);
    step(1'b0, 1'b1, 9, 8'h99);
    nop(DEPTH - 3);
    step(1'b0, 1'b1, 10, 8'h44);
    step(1'b0, 1'b0, 9, '0);
    step(1'b0, 1'b0, 10, '0);

    // Preloaded word is wiped by a one-cycle reset pulse.
    step(1'b0, 1'b1, 13, 8'hA5);
    step(1'b0, 1'b0, 13, '0);
    step(1'b1, 1'b0, 13, '0);
    nop(DEPTH);
    step(1'b0, 1'b0, 13, '0);

    // Direct accesses and write-first.
    step(1'b0, 1'b1, 8, 8'h3C);
    step(1'b0, 1'b0, 8, '0);
    step(1'b0, 1'b1, 31, 8'hFF);
    step(1'b0, 1'b0, 31, '0);

    // Out of range below BASE.
    step(1'b0, 1'b1, 7, 8'h55);
    step(1'b0, 1'b0, 7, '0);
    step(1'b0, 1'b0, 31, '0);
    step(1'b0, 1'b0, 0, '0);

`ifdef RAM_REGFILE_INDIRECT_EN
    step(1'b0, 1'b1, 0, 8'h77, 20);
    step(1'b0, 1'b0, 20, '0);
    step(1'b0, 1'b0, 0, '0, 0);
    step(1'b0, 1'b0, 0, '0, 31);
`endif

    // Reset mid-clear restarts the full clear.
    step(1'b1, 1'b0, 0, '0);
    nop(10);
    step(1'b1, 1'b0, 0, '0);
    nop(DEPTH + 2);

    // Random traffic across the whole address space with rare resets.
    for (int i = 0; i < 600; i++) begin
      step(($urandom_range(0, 199) == 0), 1'($urandom_range(0, 1)),
           int'($urandom_range(0, 31)), DW'($urandom), int'($urandom_range(0, 31)));
    end

    nop(2);
    repeat (2) @(negedge clk);
    if (sb.size() != 0) begin
      n_errors++;
      $display("FAIL drain: %0d expectations left, expected 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
